keypad_scan_ctrl: RTL and testbench

Row-scanning controller for the 4x3 telephone keypad that feeds the combinational lock FSM.
- Drives one row at a time and samples synchronised column returns.
- Debounces press and release.
- Presents the decoded key on the lock's one-hot h/v interface: h=000, v=0000 when no key is held.
- Also provides a key code plus a single-cycle strobe for display/logging logic.

---
 rtl/lock_pkg.sv | 88 ++++++++
 rtl/keypad_sync.sv | 26 ++
 rtl/keypad_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad scanner and the combination lock FSM:
// scanner states, key codes, one-hot h/v encodings and the key decoder.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_DEB_REL
  } kscan_state_e;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  // Leftmost bit is column 1 / row 1, matching the [1:3] / [1:4] port ranges.
  localparam logic [2:0] H_NONE = 3'b000;
  localparam logic [2:0] H_COL1 = 3'b100;
  localparam logic [2:0] H_COL2 = 3'b010;
  localparam logic [2:0] H_COL3 = 3'b001;

  localparam logic [3:0] V_NONE = 4'b0000;
  localparam logic [3:0] V_ROW1 = 4'b1000;
  localparam logic [3:0] V_ROW2 = 4'b0100;
  localparam logic [3:0] V_ROW3 = 4'b0010;
  localparam logic [3:0] V_ROW4 = 4'b0001;

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return V_ROW1 >> idx;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] x);
    return (x != 3'b000) && ((x & (x - 3'd1)) == 3'b000);
  endfunction

  function automatic logic [3:0] key_decode(input logic [3:0] v_row, input logic [2:0] h_col);
    logic [3:0] code;
    code = KEY_NONE;
    case (v_row)
      V_ROW1: begin
        case (h_col)
          H_COL1:  code = KEY_1;
          H_COL2:  code = KEY_2;
          H_COL3:  code = KEY_3;
          default: code = KEY_NONE;
        endcase
      end
      V_ROW2: begin
        case (h_col)
          H_COL1:  code = KEY_4;
          H_COL2:  code = KEY_5;
          H_COL3:  code = KEY_6;
          default: code = KEY_NONE;
        endcase
      end
      V_ROW3: begin
        case (h_col)
          H_COL1:  code = KEY_7;
          H_COL2:  code = KEY_8;
          H_COL3:  code = KEY_9;
          default: code = KEY_NONE;
        endcase
      end
      V_ROW4: begin
        case (h_col)
          H_COL1:  code = KEY_STAR;
          H_COL2:  code = KEY_0;
          H_COL3:  code = KEY_HASH;
          default: code = KEY_NONE;
        endcase
      end
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad column returns.
module keypad_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning 4x3 keypad controller with press/release debounce, driving the
// lock FSM's one-hot h/v interface plus a key code and press strobe.
module keypad_scan_ctrl
  import lock_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:3] col_sense,
  output logic [1:4] row_drive,
  output logic [1:3] h,
  output logic [1:4] v,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int BW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYC);

  logic [2:0] col_s;

  kscan_state_e  state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [2:0]    cand_q, cand_d;
  logic [3:0]    row_drive_q, row_drive_d;
  logic [2:0]    h_q, h_d;
  logic [3:0]    v_q, v_d;
  logic [3:0]    code_q, code_d;
  logic          strobe_q, strobe_d;
  logic          held_q, held_d;
  logic          multi_q, multi_d;

  keypad_sync #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (col_sense),
    .q_o   (col_s)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    deb_d    = deb_q;
    cand_d   = cand_q;
    h_d      = h_q;
    v_d      = v_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    held_d   = held_q;
    multi_d  = multi_q;

    if (!en) begin
      state_d = ST_IDLE;
      row_d   = 2'd0;
      dwell_d = '0;
      deb_d   = '0;
      cand_d  = 3'b000;
      h_d     = H_NONE;
      v_d     = V_NONE;
      code_d  = KEY_NONE;
      held_d  = 1'b0;
      multi_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SCAN;
          row_d   = 2'd0;
          dwell_d = '0;
        end

        // Sampling only at the end of the dwell hides the sync latency after a row change.
        ST_SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            if (col_s == 3'b000) begin
              row_d   = row_q + 2'd1;
              dwell_d = '0;
            end else begin
              cand_d  = col_s;
              deb_d   = '0;
              state_d = ST_DEB_PRESS;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end

        ST_DEB_PRESS: begin
          if (col_s != cand_q) begin
            state_d = ST_SCAN;
            dwell_d = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d = ST_PRESSED;
            h_d     = cand_q;
            v_d     = row_onehot(row_q);
            held_d  = 1'b1;
            if (is_onehot3(cand_q)) begin
              code_d   = key_decode(row_onehot(row_q), cand_q);
              strobe_d = 1'b1;
              multi_d  = 1'b0;
            end else begin
              // Raw multi-bit h is passed on so the lock sees an invalid entry.
              code_d  = KEY_NONE;
              multi_d = 1'b1;
            end
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end

        ST_PRESSED: begin
          if (col_s == 3'b000) begin
            state_d = ST_DEB_REL;
            deb_d   = '0;
          end
        end

        ST_DEB_REL: begin
          if (col_s != 3'b000) begin
            state_d = ST_PRESSED;
          end else if (deb_q == DEB_LAST) begin
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
            dwell_d = '0;
            deb_d   = '0;
            h_d     = H_NONE;
            v_d     = V_NONE;
            code_d  = KEY_NONE;
            held_d  = 1'b0;
            multi_d = 1'b0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    row_drive_d = (state_d == ST_IDLE) ? V_NONE : row_onehot(row_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      cand_q      <= 3'b000;
      row_drive_q <= V_NONE;
      h_q         <= H_NONE;
      v_q         <= V_NONE;
      code_q      <= KEY_NONE;
      strobe_q    <= 1'b0;
      held_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      cand_q      <= cand_d;
      row_drive_q <= row_drive_d;
      h_q         <= h_d;
      v_q         <= v_d;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
      held_q      <= held_d;
      multi_q     <= multi_d;
    end
  end

  assign row_drive  = row_drive_q;
  assign h          = h_q;
  assign v          = v_q;
  assign key_code   = code_q;
  assign key_strobe = strobe_q;
  assign key_held   = held_q;
  assign multi_key  = multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad matrix model, a key-vector
// table, hand-timed latency/bounce/reset sequences and a small lock model.
module tb_keypad_scan_ctrl;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:3] col_sense;
  logic [1:4] row_drive;
  logic [1:3] h;
  logic [1:4] v;
  logic [3:0] key_code;
  logic       key_strobe;
  logic       key_held;
  logic       multi_key;

  logic [11:0] pressed;
  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .col_sense  (col_sense),
    .row_drive  (row_drive),
    .h          (h),
    .v          (v),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .key_held   (key_held),
    .multi_key  (multi_key)
  );

  // Keypad matrix: a held key connects its row drive to its column return.
  always_comb begin
    col_sense = 3'b000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && row_drive[r+1]) col_sense[c+1] = 1'b1;
  end

  always @(negedge clk) if (key_strobe) strobe_cnt <= strobe_cnt + 1;

  // Lock model: steps on each accepted release, using the h/v seen while held.
  localparam logic [2:0] CODE_H [4] = '{H_COL1, H_COL1, H_COL2, H_COL2};
  localparam logic [3:0] CODE_V [4] = '{V_ROW1, V_ROW1, V_ROW4, V_ROW2};
  logic [2:0] last_h;
  logic [3:0] last_v;
  int  lock_step;
  bit  lock_open;
  bit  lock_clr;

  always @(negedge clk) begin
    if (lock_clr) begin
      lock_step <= 0;
      lock_open <= 1'b0;
      last_h    <= 3'b000;
      last_v    <= 4'b0000;
    end else if (h != 3'b000) begin
      last_h <= h;
      last_v <= v;
    end else if (last_h != 3'b000) begin
      last_h <= 3'b000;
      last_v <= 4'b0000;
      if (!lock_open) begin
        if (last_h == CODE_H[lock_step] && last_v == CODE_V[lock_step]) begin
          if (lock_step == 3) lock_open <= 1'b1;
          else lock_step <= lock_step + 1;
        end else if (last_h == CODE_H[0] && last_v == CODE_V[0]) begin
          lock_step <= 1;
        end else begin
          lock_step <= 0;
        end
      end
    end
  end

  typedef struct {
    logic [11:0] keys;
    logic [2:0]  eh;
    logic [3:0]  ev;
    logic [3:0]  ecode;
    int          estb;
    logic        emulti;
    logic [3:0]  enext;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [11:0] kb(input int r, input int c);
    return 12'd1 << ((r - 1) * 3 + (c - 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input string name);
    int i;
    i = 0;
    while (key_held !== lvl && i < 200) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (key_held !== lvl) begin
      n_bad++;
      $display("FAIL %s: key_held=%0b after %0d cycles, expected %0b", name, key_held, i, lvl);
    end
  endtask

  task automatic wait_row(input logic [3:0] row, input string name);
    int i;
    i = 0;
    while (row_drive !== row && i < 100) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(row_drive), 32'(row));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic [11:0] keys, input string name);
    pressed = keys;
    wait_held(1'b1, {name, "_press"});
    idle(3);
    pressed = 12'd0;
    wait_held(1'b0, {name, "_release"});
    idle(2);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_h"}, 32'(h), 32'(H_NONE));
    check({name, "_v"}, 32'(v), 32'(V_NONE));
    check({name, "_code"}, 32'(key_code), 32'(KEY_NONE));
    check({name, "_multi"}, 32'(multi_key), 32'd0);
  endtask

  initial begin
    int s0;
    int bounce [7];

    tbl[0] = '{kb(1,1),            H_COL1, V_ROW1, KEY_1,    1, 1'b0, V_ROW2};
    tbl[1] = '{kb(2,2),            H_COL2, V_ROW2, KEY_5,    1, 1'b0, V_ROW3};
    tbl[2] = '{kb(3,3),            H_COL3, V_ROW3, KEY_9,    1, 1'b0, V_ROW4};
    tbl[3] = '{kb(4,1),            H_COL1, V_ROW4, KEY_STAR, 1, 1'b0, V_ROW1};
    tbl[4] = '{kb(4,2),            H_COL2, V_ROW4, KEY_0,    1, 1'b0, V_ROW1};
    tbl[5] = '{kb(4,3),            H_COL3, V_ROW4, KEY_HASH, 1, 1'b0, V_ROW1};
    tbl[6] = '{kb(4,1) | kb(4,2),  3'b110, V_ROW4, KEY_NONE, 0, 1'b1, V_ROW1};
    tbl[7] = '{kb(2,3),            H_COL3, V_ROW2, KEY_6,    1, 1'b0, V_ROW3};

    pressed  = 12'd0;
    en       = 1'b1;
    reset    = 1'b0;
    lock_clr = 1'b1;

    // Reset state
    idle(3);
    check("rst_row", 32'(row_drive), 32'(V_NONE));
    check("rst_held", 32'(key_held), 32'd0);
    check_cleared("rst");
    reset = 1'b1;

    // Scan order, 4 cycles per row, outputs idle throughout
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("scan_row_c%0d", k), 32'(row_drive), 32'(row_onehot(2'((k - 1) / 4))));
    end
    check_cleared("scan");

    // Key 1 pressed at the start of row1 dwell: exact press and release latency
    s0 = strobe_cnt;
    pressed = kb(1,1);
    idle(12);
    check("lat_press_early", 32'(key_held), 32'd0);
    idle(1);
    check("lat_press_held", 32'(key_held), 32'd1);
    check("lat_press_strobe", 32'(key_strobe), 32'd1);
    idle(1);
    check("lat_strobe_width", 32'(key_strobe), 32'd0);
    pressed = 12'd0;
    idle(11);
    check("lat_rel_early", 32'(key_held), 32'd1);
    idle(1);
    check("lat_rel_done", 32'(key_held), 32'd0);
    check("lat_rel_row", 32'(row_drive), 32'(V_ROW2));
    check("lat_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Table of single and multi-key presses
    for (int i = 0; i < 8; i++) begin
      s0 = strobe_cnt;
      pressed = tbl[i].keys;
      wait_held(1'b1, $sformatf("v%0d_press", i));
      check($sformatf("v%0d_h", i), 32'(h), 32'(tbl[i].eh));
      check($sformatf("v%0d_v", i), 32'(v), 32'(tbl[i].ev));
      check($sformatf("v%0d_code", i), 32'(key_code), 32'(tbl[i].ecode));
      check($sformatf("v%0d_multi", i), 32'(multi_key), 32'(tbl[i].emulti));
      idle(5);
      pressed = 12'd0;
      wait_held(1'b0, $sformatf("v%0d_release", i));
      check_cleared($sformatf("v%0d_clr", i));
      check($sformatf("v%0d_next_row", i), 32'(row_drive), 32'(tbl[i].enext));
      idle(2);
      check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - s0), 32'(tbl[i].estb));
    end

    // Key 5 with press and release bounce shorter than the debounce window
    bounce = '{3, 2, 4, 1, 2, 3, 1};
    wait_row(V_ROW2, "bnc_row2");
    s0 = strobe_cnt;
    for (int b = 0; b < 6; b++) begin
      pressed = (b % 2 == 0) ? kb(2,2) : 12'd0;
      idle(bounce[b]);
    end
    idle(1);
    check("bnc_no_held", 32'(key_held), 32'd0);
    check("bnc_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    pressed = kb(2,2);
    wait_held(1'b1, "bnc_press");
    check("bnc_h", 32'(h), 32'(H_COL2));
    check("bnc_v", 32'(v), 32'(V_ROW2));
    check("bnc_code", 32'(key_code), 32'(KEY_5));
    idle(3);
    for (int b = 0; b < 6; b++) begin
      pressed = (b % 2 == 0) ? 12'd0 : kb(2,2);
      idle(bounce[b]);
    end
    check("bnc_still_held", 32'(key_held), 32'd1);
    pressed = 12'd0;
    wait_held(1'b0, "bnc_release");
    idle(2);
    check("bnc_one_strobe", 32'(strobe_cnt - s0), 32'd1);

    // Asynchronous reset while a key is held
    pressed = kb(3,3);
    wait_held(1'b1, "arst_press");
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_row", 32'(row_drive), 32'(V_NONE));
    check("arst_held", 32'(key_held), 32'd0);
    check("arst_strobe", 32'(key_strobe), 32'd0);
    check_cleared("arst");
    pressed = 12'd0;
    @(negedge clk);
    reset = 1'b1;

    // en dropped while a press is being debounced
    wait_row(V_ROW4, "en_row4");
    wait_row(V_ROW1, "en_row1");
    s0 = strobe_cnt;
    pressed = kb(1,1);
    idle(8);
    en = 1'b0;
    idle(1);
    check("en_row_off", 32'(row_drive), 32'(V_NONE));
    check("en_held", 32'(key_held), 32'd0);
    idle(20);
    check("en_idle_row", 32'(row_drive), 32'(V_NONE));
    check("en_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_cleared("en");
    pressed = 12'd0;
    en = 1'b1;
    idle(4);

    // Lock: 1,1,0,5 opens after the fourth release; 1,2,0,5 never opens
    lock_clr = 1'b1;
    idle(1);
    lock_clr = 1'b0;
    tap(kb(1,1), "lk_a1");
    tap(kb(1,1), "lk_a2");
    tap(kb(4,2), "lk_a3");
    check("lock_before_4th", 32'(lock_open), 32'd0);
    tap(kb(2,2), "lk_a4");
    check("lock_open", 32'(lock_open), 32'd1);

    lock_clr = 1'b1;
    idle(1);
    lock_clr = 1'b0;
    tap(kb(1,1), "lk_b1");
    tap(kb(1,2), "lk_b2");
    tap(kb(4,2), "lk_b3");
    tap(kb(2,2), "lk_b4");
    check("lock_wrong_code", 32'(lock_open), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
